axil_reg_if_wr_mux: RTL and testbench
=====================================

Name: axil_reg_if_wr_mux

Overview:
AXI-Lite write slave that decodes each write to one of PORTS register-interface ports and drives a single-access strobe/ack handshake on the selected port. It is the parametrised successor of the single-port register write interface. It adds multi-port decode, DECERR for unmapped addresses, a programmable timeout response, optional timeout disable, and zero-strobe short-circuit. It sits between an AXI-Lite interconnect and register banks of several sub-blocks.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 32, AXI-Lite address width
STRB_WIDTH, DATA_WIDTH/8, wstrb width
PORTS, 4, number of register ports (1..16)
PORT_ADDR_WIDTH, 12, byte-address span per port; reg_wr_addr width
TIMEOUT, 4, cycles to wait for ack (0 = never time out)
TIMEOUT_RESP, 2'b10, bresp on timeout (2'b00 OKAY or 2'b10 SLVERR)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  AW valid
s_axil_awready  out  1  AW ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  STRB_WIDTH  byte strobes
s_axil_wvalid  in  1  W valid
s_axil_wready  out  1  W ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  B valid
s_axil_bready  in  1  B ready
reg_wr_addr  out  PORT_ADDR_WIDTH  port-local address (awaddr[PORT_ADDR_WIDTH-1:0])
reg_wr_data  out  DATA_WIDTH  write data, shared by all ports
reg_wr_strb  out  STRB_WIDTH  strobes, shared by all ports
reg_wr_en  out  PORTS  one-hot write enable
reg_wr_wait  in  PORTS  per-port wait (freezes timeout)
reg_wr_ack  in  PORTS  per-port completion

Behaviour:
- Reset (rst_n low, asynchronous): awready=0, wready=0, bvalid=0, bresp=00, reg_wr_en=0, state IDLE, both hold registers empty, timeout counter cleared. First cycle after release: awready=wready=1.
- Decode: port index = awaddr[PORT_ADDR_WIDTH +: clog2(PORTS)]; PORTS=1 means no select bits. Unmapped if any higher address bit is nonzero or index >= PORTS.
- IDLE: AW and W are captured independently into hold registers. awready = AW hold empty; wready = W hold empty. Either may arrive first, or both in the same cycle. No further AW/W is accepted until the B handshake completes (one outstanding write).
- Both holds full -> next cycle:
  - unmapped: RESP, bresp=11 (DECERR), no reg_wr_en.
  - wstrb==0: RESP, bresp=00, no reg_wr_en.
  - otherwise: ACCESS, reg_wr_en[idx]=1, counter=TIMEOUT-1.
- Latency: AW and W accepted at edge N -> reg_wr_en high during cycle N+1.
- ACCESS: reg_wr_en[idx] stays high and addr/data/strb stay stable until ack or timeout.
  - reg_wr_ack[idx]=1 -> reg_wr_en drops next cycle, RESP, bresp=00.
  - Ack on the same cycle the counter is 0: ack wins, bresp=00.
  - Else if counter==0 and TIMEOUT!=0 -> RESP, bresp=TIMEOUT_RESP.
  - Else counter decrements when reg_wr_wait[idx]=0 and holds when it is 1.
  - TIMEOUT=0: wait forever.
  - ack/wait on non-selected ports are ignored.
- RESP: bvalid=1 with stable bresp until bready. On the handshake edge: bvalid=0, bresp=00, holds cleared, IDLE; awready=wready=1 the next cycle.
- Reset asserted mid-ACCESS or mid-RESP aborts the transaction immediately with no response.

Test Plan:
- AW addr 0x1004 and W 0xDEADBEEF/strb F in the same cycle, port1 acks 2 cycles after en -> reg_wr_en=0010 on cycle N+1, reg_wr_addr=0x004, bresp=00, bvalid one cycle after ack.
- W presented 3 cycles before AW addr 0x3010 -> wready low after capture, write lands on port3 with the buffered data, bresp=00.
- AW addr 0x5000 (PORTS=4) -> no reg_wr_en, bresp=11; same for 0x10000000.
- Port0 never acks, TIMEOUT=4, wait=0 -> en high exactly 4 cycles, bresp=10; repeat with wait held 5 cycles -> en high 9 cycles.
- wstrb=0 to a mapped address -> no enable, bresp=00; bready held low 5 cycles -> bvalid/bresp stable, awready=0 throughout.
- rst_n pulled low while en is high -> all outputs reset asynchronously; next write after release completes normally.

Source files
------------

// File: rtl/axil_reg_if_wr_mux.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_if_wr_mux
// Brief    : AXI-Lite write slave decoding each write onto one of PORTS
//            register-interface ports with a strobe/ack handshake.
// Revision : 1.0
// ============================================================================
module axil_reg_if_wr_mux #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int          PORTS           = 4,
  parameter int          PORT_ADDR_WIDTH = 12,
  parameter int          TIMEOUT         = 4,
  parameter logic [1:0]  TIMEOUT_RESP    = 2'b10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]      s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  output logic [PORT_ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0]      reg_wr_data,
  output logic [STRB_WIDTH-1:0]      reg_wr_strb,
  output logic [PORTS-1:0]           reg_wr_en,
  input  logic [PORTS-1:0]           reg_wr_wait,
  input  logic [PORTS-1:0]           reg_wr_ack
);

  localparam int SEL_BITS = (PORTS > 1) ? $clog2(PORTS) : 0;
  localparam int IDX_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    aw_full_q, aw_full_d;
  logic                    w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PORTS-1:0]        en_q, en_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    bvalid_q, bvalid_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;

  logic                    aw_fire, w_fire;
  logic [ADDR_WIDTH-1:0]   addr_in, sel_shift, upper_bits;
  logic [IDX_W-1:0]        idx_in;
  logic                    unmapped;
  logic [PORTS-1:0]        en_one;
  logic                    unused_ok;

  assign aw_fire = awready_q & s_axil_awvalid;
  assign w_fire  = wready_q & s_axil_wvalid;

  // Decode looks at the address as it will be held after this edge, so a
  // write whose last channel arrives now can start its access next cycle.
  assign addr_in    = aw_fire ? s_axil_awaddr : addr_q;
  assign sel_shift  = addr_in >> PORT_ADDR_WIDTH;
  assign upper_bits = addr_in >> (PORT_ADDR_WIDTH + SEL_BITS);
  assign idx_in     = (SEL_BITS > 0) ? sel_shift[IDX_W-1:0] : '0;
  assign unmapped   = (upper_bits != '0) || (32'(idx_in) >= PORTS);
  assign unused_ok  = ^{s_axil_awprot, sel_shift};

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bresp_d   = bresp_q;
    en_one    = '0;
    en_one[0] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (aw_fire) begin
          aw_full_d = 1'b1;
          addr_d    = s_axil_awaddr;
        end
        if (w_fire) begin
          w_full_d = 1'b1;
          data_d   = s_axil_wdata;
          strb_d   = s_axil_wstrb;
        end
        if (aw_full_d && w_full_d) begin
          if (unmapped) begin
            state_d = ST_RESP;
            bresp_d = 2'b11;
          end else if (strb_d == '0) begin
            state_d = ST_RESP;
            bresp_d = 2'b00;
          end else begin
            state_d = ST_ACCESS;
            idx_d   = idx_in;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_ACCESS: begin
        // Ack takes priority over an expiring counter.
        if (reg_wr_ack[idx_q]) begin
          state_d = ST_RESP;
          bresp_d = 2'b00;
        end else if ((TIMEOUT != 0) && (cnt_q == '0)) begin
          state_d = ST_RESP;
          bresp_d = TIMEOUT_RESP;
        end else if (!reg_wr_wait[idx_q] && (cnt_q != '0)) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (s_axil_bready) begin
          state_d   = ST_IDLE;
          bresp_d   = 2'b00;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_d      = (state_d == ST_ACCESS) ? (en_one << idx_d) : '0;
    bvalid_d  = (state_d == ST_RESP);
    awready_d = (state_d == ST_IDLE) && !aw_full_d;
    wready_d  = (state_d == ST_IDLE) && !w_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      bresp_q   <= 2'b00;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_bvalid  = bvalid_q;
  assign reg_wr_addr    = addr_q[PORT_ADDR_WIDTH-1:0];
  assign reg_wr_data    = data_q;
  assign reg_wr_strb    = strb_q;
  assign reg_wr_en      = en_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_if_wr_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_if_wr_mux
// Brief    : Directed vector bench for the multi-port AXI-Lite write mux.
// Revision : 1.0
// ============================================================================
module tb_axil_reg_if_wr_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic [3:0]  reg_wr_en;
  logic [3:0]  reg_wr_wait = '0;
  logic [3:0]  reg_wr_ack = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axil_reg_if_wr_mux dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_strb    (reg_wr_strb),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_wait    (reg_wr_wait),
    .reg_wr_ack     (reg_wr_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          ack_after;   // en-cycle index carrying the ack, -1 = never
    int          wait_cyc;    // leading en-cycles with wait asserted
    bit          noise;       // drive ack/wait on every non-selected port
    logic [3:0]  exp_en;
    int          exp_cyc;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_vec(input int n, input vec_t v);
    int en_cyc;
    bit done;
    en_cyc = 0;
    done   = 1'b0;
    awaddr = v.addr; wdata = v.data; wstrb = v.strb;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_ready", n), {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (reg_wr_en == '0) begin
        done = 1'b1;
      end else begin
        if (k == 0) begin
          chk($sformatf("v%0d_en", n), reg_wr_en, v.exp_en);
          chk($sformatf("v%0d_addr", n), reg_wr_addr, v.addr[11:0]);
          chk($sformatf("v%0d_data", n), reg_wr_data, v.data);
          chk($sformatf("v%0d_strb", n), reg_wr_strb, v.strb);
        end
        en_cyc++;
        reg_wr_ack  = (k == v.ack_after) ? reg_wr_en : '0;
        reg_wr_wait = (k < v.wait_cyc) ? reg_wr_en : '0;
        if (v.noise) begin
          reg_wr_ack  = reg_wr_ack | ~reg_wr_en;
          reg_wr_wait = reg_wr_wait | ~reg_wr_en;
        end
      end
    end
    reg_wr_ack = '0; reg_wr_wait = '0;
    chk($sformatf("v%0d_en_done", n), done, 1'b1);
    chk($sformatf("v%0d_en_cycles", n), en_cyc, v.exp_cyc);
    chk($sformatf("v%0d_bvalid", n), bvalid, 1'b1);
    chk($sformatf("v%0d_bresp", n), bresp, v.exp_bresp);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    //          addr          data          strb     ack wait noise en       cyc bresp
    vecs[0] = '{32'h0000_1004, 32'hDEAD_BEEF, 4'hF,     2, 0, 0, 4'b0010, 3, 2'b00};
    vecs[1] = '{32'h0000_5000, 32'h1234_5678, 4'hF,     0, 0, 0, 4'b0000, 0, 2'b11};
    vecs[2] = '{32'h1000_0000, 32'h8765_4321, 4'hF,     0, 0, 0, 4'b0000, 0, 2'b11};
    vecs[3] = '{32'h0000_0000, 32'h1111_2222, 4'hF,    -1, 0, 0, 4'b0001, 4, 2'b10};
    vecs[4] = '{32'h0000_0000, 32'h3333_4444, 4'hF,    -1, 5, 0, 4'b0001, 9, 2'b10};
    vecs[5] = '{32'h0000_2008, 32'h5555_6666, 4'h0,     0, 0, 0, 4'b0000, 0, 2'b00};
    vecs[6] = '{32'h0000_2FFC, 32'h0000_A5A5, 4'b0100,  0, 0, 0, 4'b0100, 1, 2'b00};
    vecs[7] = '{32'h0000_3000, 32'h7777_8888, 4'hF,    -1, 0, 1, 4'b1000, 4, 2'b10};
    vecs[8] = '{32'h0000_0040, 32'h9999_AAAA, 4'b0011,  3, 0, 0, 4'b0001, 4, 2'b00};

    // Reset state
    #2;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_en", reg_wr_en, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // W arrives three cycles ahead of AW
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0; wdata = 32'h0BAD_BAD0;
    @(negedge clk);
    chk("wfirst_wready", wready, 1'b0);
    chk("wfirst_awready", awready, 1'b1);
    chk("wfirst_no_en", reg_wr_en, 4'b0000);
    repeat (2) @(posedge clk);
    #1 awaddr = 32'h0000_3010; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_en", reg_wr_en, 4'b1000);
    chk("wfirst_addr", reg_wr_addr, 12'h010);
    chk("wfirst_data", reg_wr_data, 32'hCAFE_F00D);
    reg_wr_ack = 4'b1000;
    @(posedge clk); #1;
    reg_wr_ack = '0;
    @(negedge clk);
    chk("wfirst_en_off", reg_wr_en, 4'b0000);
    chk("wfirst_b", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;

    // Zero-strobe write held in RESP by a stalled master
    awaddr = 32'h0000_2008; wdata = 32'h1357_9BDF; wstrb = 4'h0;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_b", c), {bvalid, bresp}, 3'b100);
      chk($sformatf("stall%0d_ready_en", c), {awready, wready, reg_wr_en}, 6'b0);
    end
    #1 bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("stall_release", {bvalid, bresp, awready, wready}, 5'b00011);
    @(posedge clk); #1;

    // Reset during an access, then a normal write
    awaddr = 32'h0000_1000; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("abort_en_before", reg_wr_en, 4'b0010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_en", reg_wr_en, 4'b0000);
    chk("abort_ready", {awready, wready}, 2'b00);
    chk("abort_b", {bvalid, bresp}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(9, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
